// File: rtl/peripheral_arbiter_pkg.sv
// Shared types and helpers for the peripheral register arbiter.
// Holds the FSM state encoding and the access legality rule.
package peripheral_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Out-of-range addresses are rejected before the read-only mask is consulted.
    function automatic logic is_illegal(
        input logic [31:0] addr,
        input logic        write,
        input logic [31:0] ro_mask,
        input int unsigned regs
    );
        if (addr >= regs)
            return 1'b1;
        return write && ro_mask[addr[4:0]];
    endfunction

endpackage

// File: rtl/peripheral_rr_arbiter.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping around.
module peripheral_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        // Scanning from last_grant+1 leaves the previous winner as lowest priority.
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_grant) + i) % NREQ;
            if (!grant_any && valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/peripheral_register_arbiter.sv
// Shares the counter peripheral's register array between NREQ requesters,
// one transaction at a time: accept, access, respond.
module peripheral_register_arbiter
    import peripheral_arbiter_pkg::*;
#(
    parameter int                NREQ      = 2,
    parameter int                REGS      = 3,
    parameter int                ADDR_W    = $clog2(REGS),
    parameter int                REG_SLOTS = 2 ** ADDR_W,
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter logic [REGS-1:0]   RO_MASK   = 3'b100
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0]                     req_write,
    input  logic [NREQ-1:0][ADDR_W-1:0]         req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]         req_wdata,
    output logic [NREQ-1:0]                     rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                rsp_err,
    output logic [REG_SLOTS-1:0]                reg_write_en,
    output logic [DATA_W-1:0]                   reg_data_in,
    input  logic [REG_SLOTS-1:0][DATA_W-1:0]    reg_data_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state, state_next;
    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_write;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic               illegal;

    assign illegal = is_illegal(32'(lat_addr), lat_write, 32'(RO_MASK), REGS);

    peripheral_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Outputs are gated by reset so an asserted reset mid-ACCESS drops the strobe immediately.
    always_comb begin
        state_next   = state;
        req_ready    = '0;
        reg_write_en = '0;
        reg_data_in  = '0;
        rsp_valid    = '0;
        case (state)
            IDLE: begin
                if (grant_any)
                    state_next = ACCESS;
                if (reset)
                    req_ready = grant;
            end
            ACCESS: begin
                state_next = RESP;
                if (reset && lat_write && !illegal) begin
                    reg_write_en[lat_addr] = 1'b1;
                    reg_data_in            = lat_wdata;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (reset)
                    rsp_valid[lat_idx] = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset parks last_grant on the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= IDX_W'(NREQ - 1);
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                lat_idx    <= grant_idx;
                lat_write  <= req_write[grant_idx];
                lat_addr   <= req_addr[grant_idx];
                lat_wdata  <= req_wdata[grant_idx];
                last_grant <= grant_idx;
            end
            if (state == ACCESS) begin
                rsp_err   <= illegal;
                rsp_rdata <= (!lat_write && !illegal) ? reg_data_out[lat_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_register_arbiter.sv
// Directed bench for peripheral_register_arbiter: reset, write, read, contention,
// illegal accesses and reset in the middle of a write.
module tb_peripheral_register_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int SL   = 4;
    localparam int DW   = 32;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_write;
    logic [NREQ-1:0][AW-1:0]    req_addr;
    logic [NREQ-1:0][DW-1:0]    req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic [DW-1:0]              rsp_rdata;
    logic                       rsp_err;
    logic [SL-1:0]              reg_write_en;
    logic [DW-1:0]              reg_data_in;
    logic [SL-1:0][DW-1:0]      reg_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_register_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .reg_write_en (reg_write_en),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input int idx,
                                 input logic write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_valid       = valid;
        req_write[idx]  = write;
        req_addr[idx]   = addr;
        req_wdata[idx]  = wdata;
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;
        logic [DW-1:0]   exp_d;

        reset        = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        reg_data_out[0] = 32'hAAAA_0000;
        reg_data_out[1] = 32'h0000_0005;
        reg_data_out[2] = 32'h0000_0004;
        reg_data_out[3] = 32'hDEAD_BEEF;

        // Reset with both requesters asking: nothing may be granted.
        tick();
        applyStimulus(2'b11, 0, 1'b0, 2'd0, 32'h0);
        tick();
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_err", 32'(rsp_err), 32'h0);
        checkOutput("reset_wen", 32'(reg_write_en), 32'h0);
        checkOutput("reset_din", reg_data_in, 32'h0);
        req_valid = '0;
        reset     = 1'b1;
        tick();

        // Single write from requester 0.
        applyStimulus(2'b01, 0, 1'b1, 2'd0, 32'h0000_1234);
        checkOutput("wr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        checkOutput("wr_wen", 32'(reg_write_en), 32'h1);
        checkOutput("wr_din", reg_data_in, 32'h0000_1234);
        checkOutput("wr_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("wr_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("wr_wen_off", 32'(reg_write_en), 32'h0);
        tick();
        checkOutput("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Single read from requester 1.
        applyStimulus(2'b10, 1, 1'b0, 2'd1, 32'h0);
        checkOutput("rd_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        checkOutput("rd_wen", 32'(reg_write_en), 32'h0);
        tick();
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("rd_rdata", rsp_rdata, 32'h0000_0005);
        checkOutput("rd_err", 32'(rsp_err), 32'h0);
        tick();

        // Contention: both valid continuously, grants must alternate 0,1,0,1.
        req_write    = 2'b00;
        req_addr[0]  = 2'd0;
        req_addr[1]  = 2'd2;
        req_valid    = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 32'hAAAA_0000 : 32'h0000_0004;
            checkOutput($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(exp_g));
            tick();
            checkOutput($sformatf("cont_busy_%0d", k), 32'(req_ready), 32'h0);
            tick();
            checkOutput($sformatf("cont_rsp_%0d", k), 32'(rsp_valid), 32'(exp_g));
            checkOutput($sformatf("cont_rdata_%0d", k), rsp_rdata, exp_d);
            tick();
        end
        req_valid = '0;
        tick();

        // Write to the read-only status register.
        applyStimulus(2'b01, 0, 1'b1, 2'd2, 32'hFFFF_FFFF);
        checkOutput("ro_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        checkOutput("ro_wen", 32'(reg_write_en), 32'h0);
        checkOutput("ro_din", reg_data_in, 32'h0);
        tick();
        checkOutput("ro_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("ro_err", 32'(rsp_err), 32'h1);
        checkOutput("ro_rdata", rsp_rdata, 32'h0);
        tick();

        // Read of an unimplemented slot.
        applyStimulus(2'b10, 1, 1'b0, 2'd3, 32'h0);
        checkOutput("oor_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        checkOutput("oor_rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("oor_err", 32'(rsp_err), 32'h1);
        checkOutput("oor_rdata", rsp_rdata, 32'h0);
        tick();
        checkOutput("oor_err_hold", 32'(rsp_err), 32'h1);

        // Reset during the ACCESS cycle of a write drops it entirely.
        applyStimulus(2'b01, 0, 1'b1, 2'd1, 32'h0000_0077);
        checkOutput("mid_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        reset     = 1'b0;
        #1;
        checkOutput("mid_wen_gated", 32'(reg_write_en), 32'h0);
        tick();
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("mid_err", 32'(rsp_err), 32'h0);
        checkOutput("mid_rdata", rsp_rdata, 32'h0);
        checkOutput("mid_wen", 32'(reg_write_en), 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("mid_no_rsp", 32'(rsp_valid), 32'h0);
        req_write = 2'b00;
        req_addr[0] = 2'd0;
        req_addr[1] = 2'd1;
        req_valid = 2'b11;
        #1;
        checkOutput("post_rst_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        checkOutput("post_rst_rsp", 32'(rsp_valid), 32'h1);
        checkOutput("post_rst_rdata", rsp_rdata, 32'hAAAA_0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
